// File: rtl/ysyx_22051086_axi_pkg.sv
// Shared types and AXI encodings for the burst master slice.
package ysyx_22051086_axi_pkg;

    // One transaction at a time, so the FSM walks these states in order.
    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_W,
        S_B,
        S_RESP
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam int         LINE_BEATS = 4;

endpackage

// File: rtl/ysyx_22051086_axi_burst_master_if.sv
// Requester-side handshake plus the five AXI channels as one bundle.
// master = the burst master's view, slave = requester + memory responder.
interface ysyx_22051086_axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = 4
);
    // requester side
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic                          req_line;
    logic [ADDR_W-1:0]             req_addr;
    logic [2:0]                    req_size;
    logic [BEATS-1:0][DATA_W-1:0]  req_wdata;
    logic [DATA_W-1:0]             req_wstrb;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [BEATS-1:0][DATA_W-1:0]  resp_rdata;
    logic                          resp_err;
    // read address / data
    logic [ADDR_W-1:0]             araddr;
    logic [3:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arvalid;
    logic                          arready;
    logic [DATA_W-1:0]             rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;
    // write address / data / response
    logic [ADDR_W-1:0]             awaddr;
    logic [3:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic                          awvalid;
    logic                          awready;
    logic [DATA_W-1:0]             wdata;
    logic [DATA_W-1:0]             wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;

    modport master (
        input  req_valid, req_write, req_line, req_addr, req_size, req_wdata, req_wstrb,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output req_valid, req_write, req_line, req_addr, req_size, req_wdata, req_wstrb,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ysyx_22051086_axi_line_buf.sv
// Cache-line staging buffer: whole-line load from the requester, beat-indexed
// fill from R, beat-indexed read mux feeding W.
module ysyx_22051086_axi_line_buf #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 4,
    parameter int IDX_W  = $clog2(BEATS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [BEATS-1:0][DATA_W-1:0]  load_line,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              idx,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             rd_data,
    output logic [BEATS-1:0][DATA_W-1:0]  line_q
);

    logic [BEATS-1:0][DATA_W-1:0] slots;

    // Load wins over a beat write; the two never coincide in practice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots <= '0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (load)
                    slots[i] <= load_line[i];
                else if (wr_en && idx == IDX_W'(i))
                    slots[i] <= wr_data;
            end
        end
    end

    assign rd_data = slots[idx];
    assign line_q  = slots;

endmodule

// File: rtl/ysyx_22051086_axi_burst_master.sv
// Single-outstanding AXI burst initiator: line fill, line writeback, or one
// uncached beat. All handshake outputs are registered in the FSM.
module ysyx_22051086_axi_burst_master
    import ysyx_22051086_axi_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BEATS  = LINE_BEATS
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_22051086_axi_burst_master_if.master bus
);

    localparam int         IDX_W    = $clog2(BEATS);
    localparam logic [3:0] LEN_LINE = 4'(BEATS - 1);

    state_t     state;
    logic [2:0] beat;
    logic       err;
    logic [3:0] beat_ext;
    logic       r_last;
    logic       buf_load;
    logic [BEATS-1:0][DATA_W-1:0] buf_load_line;

    assign beat_ext = {1'b0, beat};
    // Read ends on rlast or when the counted beats reach arlen+1, whichever first.
    assign r_last   = bus.rlast || (beat_ext == bus.arlen);

    // Reads start from a cleared buffer so a dropped fill never leaks old data.
    assign buf_load      = (state == S_IDLE) && bus.req_valid;
    assign buf_load_line = bus.req_write ? bus.req_wdata : '0;

    ysyx_22051086_axi_line_buf #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_line (buf_load_line),
        .wr_en     ((state == S_R) && bus.rvalid),
        .idx       (beat[IDX_W-1:0]),
        .wr_data   (bus.rdata),
        .rd_data   (bus.wdata),
        .line_q    (bus.resp_rdata)
    );

    assign bus.resp_err = err;

    // Transaction sequencer with registered channel controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            beat           <= '0;
            err            <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.araddr     <= '0;
            bus.arlen      <= '0;
            bus.arsize     <= '0;
            bus.arburst    <= '0;
            bus.arvalid    <= 1'b0;
            bus.rready     <= 1'b0;
            bus.awaddr     <= '0;
            bus.awlen      <= '0;
            bus.awsize     <= '0;
            bus.awburst    <= '0;
            bus.awvalid    <= 1'b0;
            bus.wstrb      <= '0;
            bus.wlast      <= 1'b0;
            bus.wvalid     <= 1'b0;
            bus.bready     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        beat          <= '0;
                        err           <= 1'b0;
                        if (bus.req_write) begin
                            bus.awaddr  <= bus.req_addr;
                            bus.awlen   <= bus.req_line ? LEN_LINE : 4'd0;
                            bus.awsize  <= bus.req_line ? SIZE_8B : bus.req_size;
                            bus.awburst <= BURST_INCR;
                            bus.awvalid <= 1'b1;
                            bus.wvalid  <= 1'b1;
                            bus.wstrb   <= bus.req_line ? '1 : bus.req_wstrb;
                            bus.wlast   <= !bus.req_line;
                            state       <= S_AW_W;
                        end else begin
                            bus.araddr  <= bus.req_addr;
                            bus.arlen   <= bus.req_line ? LEN_LINE : 4'd0;
                            bus.arsize  <= bus.req_line ? SIZE_8B : bus.req_size;
                            bus.arburst <= BURST_INCR;
                            bus.arvalid <= 1'b1;
                            state       <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state       <= S_R;
                    end
                end
                S_R: begin
                    if (bus.rvalid) begin
                        beat <= beat + 3'd1;
                        err  <= err | (bus.rresp != RESP_OKAY);
                        if (r_last) begin
                            bus.rready     <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            state          <= S_RESP;
                        end
                    end
                end
                S_AW_W: begin
                    // AW and the first W beat complete independently; each valid
                    // drops on its own handshake.
                    if (bus.awready)
                        bus.awvalid <= 1'b0;
                    if (bus.wvalid && bus.wready) begin
                        bus.wvalid <= 1'b0;
                        beat       <= beat + 3'd1;
                    end
                    if ((!bus.awvalid || bus.awready) && (!bus.wvalid || bus.wready)) begin
                        if (bus.awlen == 4'd0) begin
                            bus.wlast  <= 1'b0;
                            bus.bready <= 1'b1;
                            state      <= S_B;
                        end else begin
                            bus.wvalid <= 1'b1;
                            bus.wlast  <= (bus.awlen == 4'd1);
                            state      <= S_W;
                        end
                    end
                end
                S_W: begin
                    if (bus.wready) begin
                        if (beat_ext == bus.awlen) begin
                            bus.wvalid <= 1'b0;
                            bus.wlast  <= 1'b0;
                            bus.bready <= 1'b1;
                            state      <= S_B;
                        end else begin
                            beat      <= beat + 3'd1;
                            bus.wlast <= (beat_ext + 4'd1 == bus.awlen);
                        end
                    end
                end
                S_B: begin
                    if (bus.bvalid) begin
                        err            <= err | (bus.bresp != RESP_OKAY);
                        bus.bready     <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22051086_axi_burst_master.sv
// Bench for the burst master: acts as requester and memory responder, and
// checks every transaction against the expected AXI behaviour.
module tb_ysyx_22051086_axi_burst_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22051086_axi_burst_master_if bus ();

    ysyx_22051086_axi_burst_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 1'b0; bus.req_write = 1'b0; bus.req_line = 1'b0;
        bus.req_addr   = '0;   bus.req_size  = '0;   bus.req_wdata = '0;
        bus.req_wstrb  = '0;   bus.resp_ready = 1'b0;
        bus.arready    = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
        bus.awready    = 1'b0; bus.wready = 1'b0;
        bus.bresp      = '0;   bus.bvalid = 1'b0;
    endtask

    task automatic drive_req(input bit wr, input bit line, input logic [31:0] addr,
                             input logic [2:0] size, input logic [255:0] wd, input logic [63:0] strb);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_line = line;
        bus.req_addr  = addr; bus.req_size  = size;
        bus.req_wdata = wd;   bus.req_wstrb = strb;
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Read: responder holds arready low ar_wait cycles, inserts random R gaps,
    // flags rlast on beat last_at, SLVERR on beat err_at, offers `offered` beats.
    task automatic do_read(input string nm, input logic [31:0] addr, input bit line, input logic [2:0] size,
                           input int ar_wait, input int gap_pct, input int resp_wait,
                           input int last_at, input int err_at, input int offered, input logic [255:0] pat);
        logic [63:0]  beats [8];
        logic [255:0] exp_line, r0, extra;
        logic [40:0]  ar0;
        logic         e0;
        int n_len, n_acc, acc, off, ar_seen, resp_seen, cyc, first_resp;
        bit ar_done, hold, done, ar_moved, resp_moved, wr_seen, exp_err;
        extra = rnd_line();
        for (int k = 0; k < 8; k++) beats[k] = (k < 4) ? pat[64*k +: 64] : extra[64*(k-4) +: 64];
        n_len = line ? 4 : 1;
        n_acc = (offered < n_len) ? offered : n_len;
        if (last_at >= 0 && last_at + 1 < n_acc) n_acc = last_at + 1;
        exp_err = (err_at >= 0 && err_at < n_acc);
        exp_line = '0;
        for (int k = 0; k < n_acc; k++) exp_line[64*k +: 64] = beats[k];
        acc = 0; off = 0; ar_seen = 0; resp_seen = 0; first_resp = 0;
        ar_done = 0; hold = 0; done = 0; ar_moved = 0; resp_moved = 0; wr_seen = 0;
        ar0 = '0; r0 = '0; e0 = 1'b0;

        chk({nm, "_req_ready"}, bus.req_ready, 1);
        drive_req(1'b0, line, addr, size, rnd_line(), 64'($urandom));
        step();
        bus.req_valid = 1'b0;
        cyc = 1;
        chk({nm, "_arvalid_c1"}, bus.arvalid, 1);
        while (!done && cyc < 400) begin
            // R channel: a beat once offered stays put until rready takes it
            if (ar_done && !hold && off < offered && $urandom_range(99) >= gap_pct) hold = 1;
            bus.rvalid = hold;
            bus.rdata  = hold ? beats[off] : '0;
            bus.rlast  = hold && (off == last_at);
            bus.rresp  = (hold && off == err_at) ? 2'b10 : 2'b00;
            if (hold && bus.rready) begin acc++; off++; hold = 0; end
            // AR channel
            bus.arready = 1'b0;
            if (ar_seen > 0 && !ar_done && !bus.arvalid) ar_moved = 1;
            if (bus.arvalid) begin
                if (ar_seen == 0) ar0 = {bus.araddr, bus.arlen, bus.arsize, bus.arburst};
                else if ({bus.araddr, bus.arlen, bus.arsize, bus.arburst} !== ar0) ar_moved = 1;
                bus.arready = (ar_seen >= ar_wait);
                ar_seen++;
                if (bus.arready) ar_done = 1;
            end
            // response
            bus.resp_ready = 1'b0;
            if (bus.resp_valid) begin
                if (resp_seen == 0) begin first_resp = cyc; r0 = bus.resp_rdata; e0 = bus.resp_err; end
                else if (bus.resp_rdata !== r0 || bus.resp_err !== e0) resp_moved = 1;
                bus.resp_ready = (resp_seen >= resp_wait);
                resp_seen++;
                if (bus.resp_ready) done = 1;
            end
            if (bus.awvalid || bus.wvalid || bus.bready) wr_seen = 1;
            step();
            cyc++;
        end
        idle_inputs();
        chk({nm, "_completed"}, done, 1);
        chk({nm, "_ar_fields"}, ar0, {addr, line ? 4'd3 : 4'd0, line ? 3'd3 : size, 2'b01});
        chk({nm, "_ar_held"}, {ar_moved, 32'(ar_seen)}, {1'b0, 32'(ar_wait + 1)});
        chk({nm, "_beats"}, acc, n_acc);
        chk({nm, "_err"}, e0, exp_err);
        chk({nm, "_rdata"}, line ? r0 : {192'b0, r0[63:0]}, line ? exp_line : {192'b0, beats[0]});
        chk({nm, "_resp_held"}, {resp_moved, 32'(resp_seen)}, {1'b0, 32'(resp_wait + 1)});
        chk({nm, "_no_write"}, wr_seen, 0);
        if (ar_wait == 0 && gap_pct == 0 && line) chk({nm, "_resp_cycle"}, first_resp, 6);
        chk({nm, "_back_idle"}, {bus.req_ready, bus.resp_valid}, 2'b10);
    endtask

    // Write: awready after aw_wait cycles, random W gaps, bvalid b_wait cycles
    // after AW and every W beat are done.
    task automatic do_write(input string nm, input logic [31:0] addr, input bit line, input logic [2:0] size,
                            input logic [63:0] strb, input int aw_wait, input int gap_pct, input int b_wait,
                            input int resp_wait, input logic [1:0] bresp_v);
        logic [255:0] wd, r0;
        logic [63:0]  got_d [8];
        logic [63:0]  got_s [8];
        logic         got_l [8];
        logic [40:0]  aw0;
        logic [64:0]  w_hold;
        logic         e0;
        int n_len, nw, aw_seen, resp_seen, cyc, bcnt;
        bit aw_done, done, both_c1, aw_moved, w_moved, w_pend, resp_moved, rd_seen, b_taken;
        wd = rnd_line();
        n_len = line ? 4 : 1;
        nw = 0; aw_seen = 0; resp_seen = 0; bcnt = 0;
        aw_done = 0; done = 0; aw_moved = 0; w_moved = 0; w_pend = 0; resp_moved = 0; rd_seen = 0; b_taken = 0;
        aw0 = '0; w_hold = '0; r0 = '0; e0 = 1'b0;
        for (int k = 0; k < 8; k++) begin got_d[k] = '0; got_s[k] = '0; got_l[k] = 1'b0; end

        chk({nm, "_req_ready"}, bus.req_ready, 1);
        drive_req(1'b1, line, addr, size, wd, strb);
        step();
        bus.req_valid = 1'b0;
        cyc = 1;
        both_c1 = bus.awvalid && bus.wvalid;
        while (!done && cyc < 400) begin
            // B channel, driven from progress of earlier cycles
            bus.bvalid = 1'b0;
            if (!b_taken && aw_done && nw >= n_len) begin
                if (bcnt >= b_wait) bus.bvalid = 1'b1;
                bcnt++;
            end
            bus.bresp = bus.bvalid ? bresp_v : 2'b00;
            if (bus.bvalid && bus.bready) b_taken = 1;
            // W channel
            bus.wready = 1'b0;
            if (w_pend && !bus.wvalid) w_moved = 1;
            if (bus.wvalid) begin
                if (w_pend && {bus.wdata, bus.wlast} !== w_hold) w_moved = 1;
                bus.wready = ($urandom_range(99) >= gap_pct);
                if (bus.wready) begin
                    if (nw < 8) begin got_d[nw] = bus.wdata; got_s[nw] = bus.wstrb; got_l[nw] = bus.wlast; end
                    nw++;
                    w_pend = 0;
                end else begin
                    w_pend = 1;
                    w_hold = {bus.wdata, bus.wlast};
                end
            end
            // AW channel
            bus.awready = 1'b0;
            if (aw_seen > 0 && !aw_done && !bus.awvalid) aw_moved = 1;
            if (bus.awvalid) begin
                if (aw_seen == 0) aw0 = {bus.awaddr, bus.awlen, bus.awsize, bus.awburst};
                else if ({bus.awaddr, bus.awlen, bus.awsize, bus.awburst} !== aw0) aw_moved = 1;
                bus.awready = (aw_seen >= aw_wait);
                aw_seen++;
                if (bus.awready) aw_done = 1;
            end
            // response
            bus.resp_ready = 1'b0;
            if (bus.resp_valid) begin
                if (resp_seen == 0) begin r0 = bus.resp_rdata; e0 = bus.resp_err; end
                else if (bus.resp_rdata !== r0 || bus.resp_err !== e0) resp_moved = 1;
                bus.resp_ready = (resp_seen >= resp_wait);
                resp_seen++;
                if (bus.resp_ready) done = 1;
            end
            if (bus.arvalid || bus.rready) rd_seen = 1;
            step();
            cyc++;
        end
        idle_inputs();
        chk({nm, "_completed"}, done, 1);
        chk({nm, "_aw_w_c1"}, both_c1, 1);
        chk({nm, "_aw_fields"}, aw0, {addr, line ? 4'd3 : 4'd0, line ? 3'd3 : size, 2'b01});
        chk({nm, "_aw_held"}, {aw_moved, 32'(aw_seen)}, {1'b0, 32'(aw_wait + 1)});
        chk({nm, "_w_count"}, nw, n_len);
        chk({nm, "_w_held"}, w_moved, 0);
        for (int k = 0; k < n_len; k++)
            chk($sformatf("%s_w_beat%0d", nm, k), {got_d[k], got_s[k], got_l[k]},
                {wd[64*k +: 64], line ? 64'hFFFF_FFFF_FFFF_FFFF : strb, (k == n_len - 1) ? 1'b1 : 1'b0});
        chk({nm, "_err"}, e0, (bresp_v != 2'b00));
        chk({nm, "_resp_held"}, {resp_moved, 32'(resp_seen)}, {1'b0, 32'(resp_wait + 1)});
        chk({nm, "_no_read"}, rd_seen, 0);
        chk({nm, "_back_idle"}, {bus.req_ready, bus.resp_valid}, 2'b10);
    endtask

    initial begin
        bit          rv, ln, saw_resp;
        logic [31:0] a;
        logic [2:0]  sz;
        int          nb;

        idle_inputs();
        rst = 1'b0;
        step(); step();
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_valids", {bus.resp_valid, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast, bus.bready}, 0);
        chk("rst_resp", {bus.resp_err, bus.resp_rdata}, 0);
        chk("rst_addr_len", {bus.araddr, bus.arlen, bus.awaddr, bus.awlen}, 0);
        rst = 1'b1;
        step();

        do_read("rd_line", 32'h8000_0020, 1'b1, 3'd3, 0, 0, 0, 3, -1, 4,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        do_write("wr_line", 32'h8000_1000, 1'b1, 3'd3, 64'h0, 0, 0, 0, 0, 2'b00);
        do_write("wr_single", 32'h8000_2004, 1'b0, 3'd2, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 0, 2'b00);
        do_read("rd_bp", 32'h8000_0040, 1'b1, 3'd3, 5, 40, 3, 3, -1, 4, rnd_line());
        do_read("rd_err", 32'h8000_0060, 1'b1, 3'd3, 0, 0, 0, 3, 1, 4, rnd_line());
        do_read("rd_after_err", 32'h8000_0080, 1'b1, 3'd3, 0, 0, 0, 3, -1, 4, rnd_line());
        do_read("rd_no_rlast", 32'h8000_00A0, 1'b1, 3'd3, 1, 0, 0, -1, -1, 5, rnd_line());
        do_read("rd_single", 32'h8000_0004, 1'b0, 3'd2, 0, 0, 1, 0, -1, 1, rnd_line());
        do_write("wr_bp_err", 32'h8000_3000, 1'b1, 3'd3, 64'h0, 3, 30, 2, 2, 2'b10);
        do_write("wr_after_err", 32'h8000_3020, 1'b0, 3'd3, 64'hFFFF_0000_FFFF_0000, 2, 0, 0, 0, 2'b00);

        // reset in the middle of the second read beat
        drive_req(1'b0, 1'b1, 32'h8000_0100, 3'd3, '0, '0);
        step();
        bus.req_valid = 1'b0;
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = 64'hA5A5_0000_0000_0001;
        step();
        bus.rdata = 64'hA5A5_0000_0000_0002;
        #2 rst = 1'b0;
        #1;
        chk("midrst_valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.resp_valid}, 0);
        chk("midrst_req_ready", bus.req_ready, 1);
        bus.rvalid = 1'b0;
        #2 rst = 1'b1;
        saw_resp = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.resp_valid || bus.rready) saw_resp = 1;
        end
        chk("midrst_quiet", saw_resp, 0);
        chk("midrst_released", {bus.req_ready, bus.resp_err}, 2'b10);
        do_read("rd_post_rst", 32'h8000_0100, 1'b1, 3'd3, 0, 0, 0, 3, -1, 4, rnd_line());

        // randomized mix
        for (int t = 0; t < 12; t++) begin
            rv = $urandom_range(1);
            ln = $urandom_range(1);
            sz = ln ? 3'd3 : 3'($urandom_range(3));
            a  = ln ? ($urandom & 32'hFFFF_FFE0) : (($urandom >> sz) << sz);
            nb = ln ? 4 : 1;
            if (rv)
                do_read($sformatf("rnd%0d_rd", t), a, ln, sz, $urandom_range(3), $urandom_range(50),
                        $urandom_range(3), nb - 1, ($urandom_range(1) != 0) ? $urandom_range(nb - 1) : -1,
                        nb, rnd_line());
            else
                do_write($sformatf("rnd%0d_wr", t), a, ln, sz, {$urandom, $urandom}, $urandom_range(3),
                         $urandom_range(50), $urandom_range(3), $urandom_range(3),
                         ($urandom_range(3) == 0) ? 2'b10 : 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
